// File: rtl/ex_pkg.sv
// ============================================================================
// Module   : ex_pkg
// Purpose  : Shared EX-stage encodings: ALU opcodes, forwarding selects and
//            multiplier state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_ADD   = 4'd2;
    localparam logic [3:0] ALU_XOR   = 4'd3;
    localparam logic [3:0] ALU_NOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SUB   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;
    localparam logic [3:0] ALU_MULT  = 4'd12;
    localparam logic [3:0] ALU_MULTU = 4'd13;
    localparam logic [3:0] ALU_MFHI  = 4'd14;
    localparam logic [3:0] ALU_MFLO  = 4'd15;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    // Opcodes that launch the iterative multiplier.
    function automatic logic is_mul_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    // Opcodes that depend on (or overwrite) HI/LO.
    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_MFHI) || (op == ALU_MFLO);
    endfunction

endpackage : ex_pkg

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module   : mult_seq
// Purpose  : Iterative shift-add multiplier (one step per cycle) owning HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_seq
    import ex_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_signed,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    localparam int             CW   = $clog2(MUL_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(MUL_CYCLES - 1);

    mul_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DW-1:0]   mcand_q, mcand_d;
    logic [2*DW-1:0] prod_q,  prod_d;
    logic            neg_q,   neg_d;
    logic [DW-1:0]   hi_q,    hi_d;
    logic [DW-1:0]   lo_q,    lo_d;

    logic [DW-1:0]   w_abs_a;
    logic [DW-1:0]   w_abs_b;
    logic [DW:0]     w_sum;
    logic [2*DW-1:0] w_step;
    logic [2*DW-1:0] w_final;

    assign w_abs_a = (is_signed && a[DW-1]) ? -a : a;
    assign w_abs_b = (is_signed && b[DW-1]) ? -b : b;

    // Upper half accumulates, lower half holds the unconsumed multiplier bits.
    assign w_sum   = {1'b0, prod_q[2*DW-1:DW]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign w_step  = {w_sum, prod_q[DW-1:1]};
    assign w_final = neg_q ? -w_step : w_step;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done    = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d = MUL_BUSY;
                    mcand_d = w_abs_a;
                    prod_d  = {{DW{1'b0}}, w_abs_b};
                    neg_d   = is_signed & (a[DW-1] ^ b[DW-1]);
                    count_d = '0;
                end
            end
            MUL_BUSY: begin
                prod_d  = w_step;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    done           = 1'b1;
                    state_d        = MUL_IDLE;
                    {hi_d, lo_d}   = w_final;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == MUL_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : mult_seq

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : EX-stage operand forwarding, ALU and HI/LO multiplier, followed
//            by the EX/MEM pipeline register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int DW         = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] rs_data_ex,
    input  logic [DW-1:0] rt_data_ex,
    input  logic [DW-1:0] imm_ex,
    input  logic [4:0]    shamt_ex,
    input  logic [3:0]    alu_ctrl_ex,
    input  logic          ALUSrc_ex,
    input  logic [4:0]    rd_ex,
    input  logic          RegWrite_ex,
    input  logic          MemRead_ex,
    input  logic          MemWrite_ex,
    input  logic          MemtoReg_ex,
    input  logic [1:0]    forwardA,
    input  logic [1:0]    forwardB,
    input  logic [DW-1:0] wb_data,
    input  logic          mem_stall,
    input  logic          flush_ex,
    output logic          ex_busy,
    output logic [DW-1:0] alu_result_mem,
    output logic [DW-1:0] write_data_mem,
    output logic [4:0]    rd_mem,
    output logic          RegWrite_mem,
    output logic          MemRead_mem,
    output logic          MemWrite_mem,
    output logic          MemtoReg_mem
);

    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] wdata_q,  wdata_d;
    logic [4:0]    rd_q,     rd_d;
    logic          rw_q,     rw_d;
    logic          mr_q,     mr_d;
    logic          mw_q,     mw_d;
    logic          m2r_q,    m2r_d;

    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_op_b_pre;
    logic [DW-1:0] w_op_b;
    logic [DW-1:0] w_alu_res;
    logic [DW-1:0] w_hi;
    logic [DW-1:0] w_lo;
    logic          w_is_mul;
    logic          w_mul_start;
    logic          w_mul_busy;
    logic          w_mul_done;

    always_comb begin
        case (forwardA)
            FWD_MEM: w_op_a = result_q;
            FWD_WB:  w_op_a = wb_data;
            default: w_op_a = rs_data_ex;
        endcase
    end

    always_comb begin
        case (forwardB)
            FWD_MEM: w_op_b_pre = result_q;
            FWD_WB:  w_op_b_pre = wb_data;
            default: w_op_b_pre = rt_data_ex;
        endcase
    end

    assign w_op_b = ALUSrc_ex ? imm_ex : w_op_b_pre;

    always_comb begin
        w_alu_res = '0;
        case (alu_ctrl_ex)
            ALU_AND:  w_alu_res = w_op_a & w_op_b;
            ALU_OR:   w_alu_res = w_op_a | w_op_b;
            ALU_ADD:  w_alu_res = w_op_a + w_op_b;
            ALU_XOR:  w_alu_res = w_op_a ^ w_op_b;
            ALU_NOR:  w_alu_res = ~(w_op_a | w_op_b);
            ALU_SLL:  w_alu_res = w_op_b << shamt_ex;
            ALU_SRL:  w_alu_res = w_op_b >> shamt_ex;
            ALU_SRA:  w_alu_res = $signed(w_op_b) >>> shamt_ex;
            ALU_SUB:  w_alu_res = w_op_a - w_op_b;
            ALU_SLT:  w_alu_res = {{(DW-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_SLTU: w_alu_res = {{(DW-1){1'b0}}, (w_op_a < w_op_b)};
            ALU_LUI:  w_alu_res = {w_op_b[15:0], 16'h0000};
            ALU_MFHI: w_alu_res = w_hi;
            ALU_MFLO: w_alu_res = w_lo;
            default:  w_alu_res = '0;
        endcase
    end

    assign w_is_mul    = is_mul_op(alu_ctrl_ex);
    // mult_seq only honours start while idle, so a MULT held by ex_busy launches once it frees up.
    assign w_mul_start = w_is_mul & ~mem_stall & ~flush_ex;
    assign ex_busy     = w_mul_busy & is_hilo_op(alu_ctrl_ex) & ~flush_ex;

    mult_seq #(
        .DW         (DW),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mult_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_mul_start),
        .is_signed (alu_ctrl_ex == ALU_MULT),
        .a         (w_op_a),
        .b         (w_op_b),
        .busy      (w_mul_busy),
        .done      (w_mul_done),
        .hi        (w_hi),
        .lo        (w_lo)
    );

    mul_done_implies_busy: assert property (@(posedge clk) disable iff (!rst_n)
        w_mul_done |-> w_mul_busy);

    always_comb begin
        result_d = result_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        m2r_d    = m2r_q;
        if (!mem_stall) begin
            if (flush_ex || ex_busy) begin
                result_d = '0;
                wdata_d  = '0;
                rd_d     = '0;
                rw_d     = 1'b0;
                mr_d     = 1'b0;
                mw_d     = 1'b0;
                m2r_d    = 1'b0;
            end else begin
                result_d = w_alu_res;
                wdata_d  = w_op_b_pre;
                rd_d     = rd_ex;
                rw_d     = RegWrite_ex & ~w_is_mul;
                mr_d     = MemRead_ex;
                mw_d     = MemWrite_ex;
                m2r_d    = MemtoReg_ex;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            m2r_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            m2r_q    <= m2r_d;
        end
    end

    assign alu_result_mem = result_q;
    assign write_data_mem = wdata_q;
    assign rd_mem         = rd_q;
    assign RegWrite_mem   = rw_q;
    assign MemRead_mem    = mr_q;
    assign MemWrite_mem   = mw_q;
    assign MemtoReg_mem   = m2r_q;

endmodule : ex_mem_stage

`default_nettype wire
